// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, command codes and state encodings for the SPI slave
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Sub-phase inside WRITE/READ_ADD/READ_DATA
    typedef enum logic [1:0] {
        P_RX,
        P_WAIT,
        P_SHIFT,
        P_DONE
    } phase_t;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - MOSI serial-in/parallel-out and MISO parallel-load/serial-out shifter
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift_in,
    input  logic               sin,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               shift_out,
    output logic [FRAME_W-1:0] rx_next,
    output logic               sout
);

    logic [FRAME_W-2:0] rx_sr;
    logic [DATA_W-1:0]  tx_sr;

    // Frame as it will look once the current MOSI bit is taken in
    assign rx_next = {rx_sr, sin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr <= '0;
            tx_sr <= '0;
            sout  <= 1'b0;
        end else begin
            sout <= 1'b0;
            if (clr) begin
                rx_sr <= '0;
                tx_sr <= '0;
            end else begin
                if (shift_in) begin
                    rx_sr <= rx_next[FRAME_W-2:0];
                end
                if (load) begin
                    tx_sr <= load_data;
                end else if (shift_out) begin
                    sout  <= tx_sr[DATA_W-1];
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave frame FSM for RAM access; SPI_SLAVE_ASSERT_EN enables protocol assertions
module spi_slave
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    state_t             state;
    phase_t             phase;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   tx_cnt;
    logic               rd_addr_flag;
    logic               frame_state;
    logic               sr_clr;
    logic               sr_shift_in;
    logic               sr_load;
    logic               sr_shift_out;
    logic [FRAME_W-1:0] rx_next;

    assign frame_state  = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign sr_clr       = SS_n || (state == IDLE);
    assign sr_shift_in  = !SS_n && ((state == CHK_CMD) || (frame_state && phase == P_RX));
    assign sr_load      = !SS_n && (state == READ_DATA) && (phase == P_WAIT) && tx_valid;
    assign sr_shift_out = !SS_n && (state == READ_DATA) && (phase == P_SHIFT) && (tx_cnt != TX_LAST);

    spi_shift_reg u_shift_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (sr_clr),
        .shift_in  (sr_shift_in),
        .sin       (MOSI),
        .load      (sr_load),
        .load_data (tx_data),
        .shift_out (sr_shift_out),
        .rx_next   (rx_next),
        .sout      (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= P_RX;
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rd_addr_flag <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Slave deselect aborts any frame; rd_addr_flag deliberately survives
            if (SS_n && state != IDLE) begin
                state   <= IDLE;
                phase   <= P_RX;
                bit_cnt <= '0;
                tx_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        phase   <= P_RX;
                        bit_cnt <= '0;
                        tx_cnt  <= '0;
                        if (!SS_n) begin
                            state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        bit_cnt <= CNT_W'(1);
                        if (!MOSI) begin
                            state <= WRITE;
                        end else if (!rd_addr_flag) begin
                            state <= READ_ADD;
                        end else begin
                            state <= READ_DATA;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        case (phase)
                            P_RX: begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == RX_LAST) begin
                                    rx_data  <= rx_next;
                                    rx_valid <= 1'b1;
                                    phase    <= (state == READ_DATA) ? P_WAIT : P_DONE;
                                    if (state == READ_ADD) begin
                                        rd_addr_flag <= 1'b1;
                                    end
                                end
                            end
                            P_WAIT: begin
                                if (tx_valid) begin
                                    phase  <= P_SHIFT;
                                    tx_cnt <= '0;
                                end
                            end
                            P_SHIFT: begin
                                if (tx_cnt == TX_LAST) begin
                                    rd_addr_flag <= 1'b0;
                                    phase        <= P_DONE;
                                end else begin
                                    tx_cnt <= tx_cnt + 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_ASSERT_EN
    a_rx_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |=> !rx_valid);
    a_rx_valid_selected: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |-> $past(!SS_n));
    a_miso_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        MISO |-> $past(sr_shift_out));
    a_tx_after_rx: assert property (@(posedge clk) disable iff (!rst_n)
        (state == READ_DATA && tx_valid) |-> (phase != P_RX));
`endif

endmodule
